// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg
//   Shared types and BCD helpers for the four-digit countdown timer.
//   - state_t      : controller states
//   - bcd_digit_t  : one BCD digit (always 0..9)
//   - bcd_time_t   : tens/units seconds, deci/centi fractions
//   - LED_FLASH_*  : LED patterns shown while expired
//   - bcd_decrement / bcd_add_second : digit arithmetic with BCD carry/borrow
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t units;
        bcd_digit_t deci;
        bcd_digit_t centi;
    } bcd_time_t;

    localparam bcd_time_t  BCD_ZERO      = '0;
    localparam logic [7:0] LED_FLASH_ON  = 8'hFF;
    localparam logic [7:0] LED_FLASH_OFF = 8'h00;

    // Subtract one centisecond with borrow rippling up through the digits.
    // Never called with 00.00 (RUN always holds a nonzero value).
    function automatic bcd_time_t bcd_decrement(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.centi != 4'd0) begin
            r.centi = t.centi - 4'd1;
        end else begin
            r.centi = 4'd9;
            if (t.deci != 4'd0) begin
                r.deci = t.deci - 4'd1;
            end else begin
                r.deci = 4'd9;
                if (t.units != 4'd0) begin
                    r.units = t.units - 4'd1;
                end else begin
                    r.units = 4'd9;
                    r.tens  = (t.tens != 4'd0) ? t.tens - 4'd1 : 4'd9;
                end
            end
        end
        return r;
    endfunction

    // Add one whole second, 99 wraps to 00, fractions cleared.
    function automatic bcd_time_t bcd_add_second(input bcd_time_t t);
        bcd_time_t r;
        r.centi = 4'd0;
        r.deci  = 4'd0;
        r.tens  = t.tens;
        if (t.units == 4'd9) begin
            r.units = 4'd0;
            r.tens  = (t.tens == 4'd9) ? 4'd0 : t.tens + 4'd1;
        end else begin
            r.units = t.units + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// button_conditioner
//   Turns a raw, asynchronous, bouncing pushbutton into a single-cycle pulse.
//   Two-flop synchroniser, rising-edge detect, then a lockout window of
//   DEBOUNCE cycles during which further edges are ignored.
//   Ports:
//     CLK_50M  in  1  clock
//     RST_N    in  1  asynchronous active-low reset
//     btn      in  1  raw button level (active-high)
//     pulse    out 1  one-cycle pulse per accepted press (3 cycles after btn)
module button_conditioner #(
    parameter int DEBOUNCE = 10000000
) (
    input  logic CLK_50M,
    input  logic RST_N,
    input  logic btn,
    output logic pulse
);

    localparam int LW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

    logic          sync1;
    logic          sync2;
    logic          sync2_d;
    logic [LW-1:0] lockout;
    logic          accept;

    assign accept = sync2 && !sync2_d && (lockout == '0);

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // synchroniser chain into a single flop.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            pulse   <= 1'b0;
            lockout <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            sync2_d <= sync2;
            pulse   <= accept;
            if (accept) begin
                lockout <= LW'(DEBOUNCE);
            end else if (lockout != '0) begin
                lockout <= lockout - LW'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd
//   Four-digit BCD countdown timer, 00.00 .. 99.99 s, one decrement per
//   centisecond tick. Preset entered with EAST, started/paused with SOUTH,
//   cleared with NORTH. On expiry DONE rises and the LEDs flash.
//   Ports:
//     CLK_50M    in  1  50 MHz clock
//     RST_N      in  1  asynchronous active-low reset
//     BTN_SOUTH  in  1  start / pause / acknowledge expiry
//     BTN_EAST   in  1  +1 s (IDLE only)
//     BTN_NORTH  in  1  clear to 00.00 and return to IDLE
//     SW         in  1  0: LED = {deci,centi}, 1: LED = {tens,units}
//     LED        out 8  two BCD digits, or flash pattern while expired
//     DONE       out 1  high while expired
module countdown_timer_bcd
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV    = 500000,
    parameter int DEBOUNCE    = 10000000,
    parameter int BLINK_TICKS = 50
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic       BTN_SOUTH,
    input  logic       BTN_EAST,
    input  logic       BTN_NORTH,
    input  logic       SW,
    output logic [7:0] LED,
    output logic       DONE
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic south_pulse, east_pulse, north_pulse;

    state_t        state_q, state_d;
    bcd_time_t     time_q, time_d;
    bcd_time_t     preset_q, preset_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [7:0]    led_q, led_d;
    logic          done_q, done_d;
    logic          counting;
    logic          tick;

    button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_btn_south (
        .CLK_50M (CLK_50M),
        .RST_N   (RST_N),
        .btn     (BTN_SOUTH),
        .pulse   (south_pulse)
    );

    button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_btn_east (
        .CLK_50M (CLK_50M),
        .RST_N   (RST_N),
        .btn     (BTN_EAST),
        .pulse   (east_pulse)
    );

    button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_btn_north (
        .CLK_50M (CLK_50M),
        .RST_N   (RST_N),
        .btn     (BTN_NORTH),
        .pulse   (north_pulse)
    );

    assign counting = (state_q == RUN) || (state_q == EXPIRED);
    assign tick     = counting && (presc_q == TICK_LAST);

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            time_q        <= BCD_ZERO;
            preset_q      <= BCD_ZERO;
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            led_q         <= 8'h00;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            time_q        <= time_d;
            preset_q      <= preset_d;
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_q         <= led_d;
            done_q        <= done_d;
        end
    end

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        time_d        = time_q;
        preset_d      = preset_q;
        presc_d       = '0;
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;

        // NORTH beats SOUTH beats EAST; a button pulse also beats a tick
        // landing on the same cycle.
        if (north_pulse) begin
            time_d  = BCD_ZERO;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (south_pulse) begin
                        if (time_q != BCD_ZERO) begin
                            preset_d = time_q;
                            state_d  = RUN;
                        end
                    end else if (east_pulse) begin
                        time_d = bcd_add_second(time_q);
                    end
                end
                RUN: begin
                    if (south_pulse) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        time_d = bcd_decrement(time_q);
                        if (time_d == BCD_ZERO) begin
                            state_d = EXPIRED;
                        end
                    end
                end
                PAUSE: begin
                    if (south_pulse) begin
                        state_d = RUN;
                    end
                end
                EXPIRED: begin
                    if (south_pulse) begin
                        time_d  = preset_q;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Prescaler restarts on any state change, so partial ticks are lost
        // on pause and the first tick after entry is a full TICK_DIV away.
        if (counting && (state_d == state_q) && !tick) begin
            presc_d = presc_q + PW'(1);
        end

        if ((state_q == EXPIRED) && (state_d == EXPIRED)) begin
            blink_cnt_d   = blink_cnt_q;
            blink_phase_d = blink_phase_q;
            if (tick) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = !blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BW'(1);
                end
            end
        end

        done_d = (state_q == EXPIRED);
        if (state_q == EXPIRED) begin
            led_d = blink_phase_q ? LED_FLASH_OFF : LED_FLASH_ON;
        end else if (SW) begin
            led_d = {time_q.tens, time_q.units};
        end else begin
            led_d = {time_q.deci, time_q.centi};
        end
    end

    assign LED  = led_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Bench for countdown_timer_bcd with small timing parameters.
// A behavioural model (time kept as integer centiseconds, buttons as sampled
// histories plus an acceptance timestamp) predicts LED/DONE every cycle;
// directed sequences add hand-computed literal expectations.
module tb_countdown_timer_bcd;

    localparam int TICK_DIV    = 4;
    localparam int DEBOUNCE    = 8;
    localparam int BLINK_TICKS = 2;

    localparam int B_NORTH = 0;
    localparam int B_SOUTH = 1;
    localparam int B_EAST  = 2;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSE   = 2;
    localparam int M_EXPIRED = 3;

    logic       CLK_50M   = 1'b0;
    logic       RST_N     = 1'b0;
    logic       BTN_SOUTH = 1'b0;
    logic       BTN_EAST  = 1'b0;
    logic       BTN_NORTH = 1'b0;
    logic       SW        = 1'b0;
    logic [7:0] LED;
    logic       DONE;

    int n_checks = 0;
    int n_pass   = 0;

    countdown_timer_bcd #(
        .TICK_DIV    (TICK_DIV),
        .DEBOUNCE    (DEBOUNCE),
        .BLINK_TICKS (BLINK_TICKS)
    ) dut (
        .CLK_50M   (CLK_50M),
        .RST_N     (RST_N),
        .BTN_SOUTH (BTN_SOUTH),
        .BTN_EAST  (BTN_EAST),
        .BTN_NORTH (BTN_NORTH),
        .SW        (SW),
        .LED       (LED),
        .DONE      (DONE)
    );

    always #5 CLK_50M = ~CLK_50M;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int         m_mode   = M_IDLE;
    int         m_cs     = 0;      // remaining time in centiseconds
    int         m_preset = 0;
    int         m_entry  = 0;      // edge index at which RUN/EXPIRED was entered
    int         m_edge   = 0;
    bit         raw_hist [3][3];   // [button][k]: level sampled k+1 edges ago
    bit         m_pulse  [3];
    int         m_last_acc [3] = '{-1000000, -1000000, -1000000};
    logic [7:0] exp_led  = 8'h00;
    logic       exp_done = 1'b0;

    function automatic logic [7:0] two_digits(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_step();
        bit raw [3];
        bit tick;
        int ticks;
        raw[B_NORTH] = BTN_NORTH;
        raw[B_SOUTH] = BTN_SOUTH;
        raw[B_EAST]  = BTN_EAST;
        if (!RST_N) begin
            m_mode = M_IDLE; m_cs = 0; m_preset = 0; m_entry = 0; m_edge = 0;
            exp_led = 8'h00; exp_done = 1'b0;
            for (int b = 0; b < 3; b++) begin
                m_pulse[b] = 1'b0;
                m_last_acc[b] = -1000000;
                for (int k = 0; k < 3; k++) raw_hist[b][k] = 1'b0;
            end
            return;
        end
        m_edge++;

        // Registered outputs reflect the state held before this edge.
        if (m_mode == M_EXPIRED) begin
            ticks    = (m_edge - 1 - m_entry) / TICK_DIV;
            exp_led  = (((ticks / BLINK_TICKS) % 2) == 0) ? 8'hFF : 8'h00;
            exp_done = 1'b1;
        end else begin
            exp_led  = SW ? two_digits(m_cs / 100) : two_digits(m_cs % 100);
            exp_done = 1'b0;
        end

        tick = ((m_mode == M_RUN) || (m_mode == M_EXPIRED)) &&
               (m_edge > m_entry) && (((m_edge - m_entry) % TICK_DIV) == 0);

        if (m_pulse[B_NORTH]) begin
            m_cs = 0; m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE:
                    if (m_pulse[B_SOUTH]) begin
                        if (m_cs != 0) begin
                            m_preset = m_cs; m_mode = M_RUN; m_entry = m_edge;
                        end
                    end else if (m_pulse[B_EAST]) begin
                        m_cs = (((m_cs / 100) + 1) % 100) * 100;
                    end
                M_RUN:
                    if (m_pulse[B_SOUTH]) m_mode = M_PAUSE;
                    else if (tick) begin
                        m_cs--;
                        if (m_cs == 0) begin m_mode = M_EXPIRED; m_entry = m_edge; end
                    end
                M_PAUSE:
                    if (m_pulse[B_SOUTH]) begin m_mode = M_RUN; m_entry = m_edge; end
                default:
                    if (m_pulse[B_SOUTH]) begin m_cs = m_preset; m_mode = M_IDLE; end
            endcase
        end

        // A pulse appears three edges after the level change, unless an
        // accepted press happened within the last DEBOUNCE edges.
        for (int b = 0; b < 3; b++) begin
            m_pulse[b] = raw_hist[b][1] && !raw_hist[b][2] &&
                         ((m_edge - m_last_acc[b]) > DEBOUNCE);
            if (m_pulse[b]) m_last_acc[b] = m_edge;
            raw_hist[b][2] = raw_hist[b][1];
            raw_hist[b][1] = raw_hist[b][0];
            raw_hist[b][0] = raw[b];
        end
    endtask

    initial forever begin
        @(posedge CLK_50M or negedge RST_N);
        model_step();
    end

    initial forever begin
        @(negedge CLK_50M);
        check("model_led", LED, exp_led);
        check("model_done", DONE, exp_done);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK_50M);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_NORTH: BTN_NORTH = v;
            B_SOUTH: BTN_SOUTH = v;
            default: BTN_EAST  = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        wait_cycles(2);
        set_btn(b, 1'b0);
        wait_cycles(18);
    endtask

    // ---------------- directed sequences, then random ----------------
    initial begin
        int cnt;

        // Reset and preset entry
        wait_cycles(3);
        check("reset_led", LED, 8'h00);
        check("reset_done", DONE, 1'b0);
        RST_N = 1'b1;
        wait_cycles(2);
        for (int i = 0; i < 3; i++) press(B_EAST);
        SW = 1'b1;
        wait_cycles(2);
        check("preset_led", LED, 8'h03);
        check("preset_done", DONE, 1'b0);

        // Borrow chain from 10.00
        for (int i = 0; i < 7; i++) press(B_EAST);
        check("preset_10", LED, 8'h10);
        BTN_SOUTH = 1'b1;
        wait_cycles(2);
        BTN_SOUTH = 1'b0;
        wait_cycles(7);
        check("borrow_secs", LED, 8'h09);
        SW = 1'b0;
        wait_cycles(1);
        check("borrow_frac", LED, 8'h99);

        // Seconds wrap 99 -> 00
        press(B_NORTH);
        SW = 1'b1;
        for (int i = 0; i < 99; i++) press(B_EAST);
        check("east_99", LED, 8'h99);
        press(B_EAST);
        check("east_wrap", LED, 8'h00);

        // Expiry from 01.00
        press(B_EAST);
        check("preset_01", LED, 8'h01);
        BTN_SOUTH = 1'b1;
        cnt = 0;
        while (cnt < 1000 && DONE !== 1'b1) begin
            @(negedge CLK_50M);
            cnt++;
            if (cnt == 2) BTN_SOUTH = 1'b0;
        end
        check("expiry_latency", 16'(cnt), 16'd405);
        check("blink_first", LED, 8'hFF);
        wait_cycles(7);
        check("blink_on_end", LED, 8'hFF);
        wait_cycles(1);
        check("blink_off", LED, 8'h00);
        wait_cycles(7);
        check("blink_off_end", LED, 8'h00);
        wait_cycles(1);
        check("blink_on_again", LED, 8'hFF);
        check("expired_done", DONE, 1'b1);
        press(B_SOUTH);
        check("reload_led", LED, 8'h01);
        check("reload_done", DONE, 1'b0);

        // Zero start ignored, then pause/resume
        press(B_NORTH);
        press(B_SOUTH);
        wait_cycles(10);
        check("zero_start_led", LED, 8'h00);
        check("zero_start_done", DONE, 1'b0);
        press(B_EAST);
        check("zero_start_idle", LED, 8'h01);
        SW = 1'b0;
        BTN_SOUTH = 1'b1;
        wait_cycles(2);
        BTN_SOUTH = 1'b0;
        wait_cycles(19);
        BTN_SOUTH = 1'b1;
        wait_cycles(2);
        BTN_SOUTH = 1'b0;
        wait_cycles(50);
        check("pause_hold", LED, 8'h95);
        BTN_SOUTH = 1'b1;
        wait_cycles(2);
        BTN_SOUTH = 1'b0;
        wait_cycles(6);
        check("resume_before", LED, 8'h95);
        wait_cycles(1);
        check("resume_first_dec", LED, 8'h94);

        // Same-cycle NORTH and SOUTH while running
        wait_cycles(10);
        BTN_SOUTH = 1'b1;
        BTN_NORTH = 1'b1;
        wait_cycles(2);
        BTN_SOUTH = 1'b0;
        BTN_NORTH = 1'b0;
        wait_cycles(38);
        check("prio_frac", LED, 8'h00);
        check("prio_done", DONE, 1'b0);

        // Bouncing SOUTH yields a single start
        SW = 1'b1;
        press(B_EAST);
        SW = 1'b0;
        for (int i = 0; i < 6; i++) begin
            BTN_SOUTH = ((i % 2) == 0);
            @(negedge CLK_50M);
        end
        wait_cycles(34);
        check("bounce_run", LED, 8'h92);

        // Asynchronous reset while running
        @(posedge CLK_50M);
        #2 RST_N = 1'b0;
        #1;
        check("areset_led", LED, 8'h00);
        check("areset_done", DONE, 1'b0);
        @(negedge CLK_50M);
        RST_N = 1'b1;

        // Randomised buttons and display select
        for (int i = 0; i < 8000; i++) begin
            @(negedge CLK_50M);
            if ($urandom_range(0, 99) < 6) BTN_EAST  = ~BTN_EAST;
            if ($urandom_range(0, 99) < 2) BTN_SOUTH = ~BTN_SOUTH;
            if ($urandom_range(0, 999) < 3) BTN_NORTH = ~BTN_NORTH;
            if ($urandom_range(0, 99) < 5) SW = ~SW;
            if (i == 4000) RST_N = 1'b0;
            if (i == 4003) RST_N = 1'b1;
        end
        BTN_EAST = 1'b0;
        BTN_SOUTH = 1'b0;
        BTN_NORTH = 1'b0;
        wait_cycles(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer_bcd.md
# countdown_timer_bcd

Four-digit BCD countdown timer (00.00 to 99.99 s) for the board-level LED display, the counting-down counterpart of the up-counting stopwatch. The preset is entered with pushbuttons, and the timer decrements once per centisecond tick derived from CLK_50M. DONE is asserted and the LEDs flash on expiry. SW selects which digit pair drives LED.

## Interface
- TICK_DIV, 500000: CLK_50M cycles per centisecond tick (100 Hz).
- DEBOUNCE, 10000000: lockout cycles after an accepted button edge (0.2 s).
- BLINK_TICKS, 50: ticks per LED flash half-period in EXPIRED (0.5 s).
- CLK_50M  in  1  sole clock, 50 MHz.
- RST_N  in  1  reset, asynchronous, active-low.
- BTN_SOUTH  in  1  start/pause, active-high, asynchronous to clock.
- BTN_EAST  in  1  add 1 s to preset (IDLE only).
- BTN_NORTH  in  1  clear to 00.00, return to IDLE.
- SW  in  1  display select: 0 shows {deci,centi}, 1 shows {tens,units}.
- LED  out  8  two BCD digits, high nibble = more significant digit.
- DONE  out  1  high while in EXPIRED.

## Operation
- Digits: tens, units, deci, centi. Each is 4-bit BCD, always within 0..9. A preset register holds the last started value.
- Buttons: 2-FF synchroniser, then rising-edge detect, giving a 1-cycle pulse. Further edges are ignored for DEBOUNCE cycles after an accepted edge.
- Same-cycle pulse priority: NORTH > SOUTH > EAST. Only the winning pulse acts; the others are dropped.
- States: IDLE, RUN, PAUSE, EXPIRED.
- IDLE:
  - EAST adds 1 to units, carrying into tens. 99 wraps to 00. deci and centi are forced to 0.
  - SOUTH with a nonzero value copies the digits to preset and goes to RUN.
  - SOUTH with value 00.00 is ignored.
- RUN: on each tick, decrement the four digits with BCD borrow (e.g. 10.00 → 09.99). A decrement that reaches 00.00 goes to EXPIRED. SOUTH goes to PAUSE.
- PAUSE: digits hold. SOUTH returns to RUN. EAST is ignored.
- EXPIRED:
  - DONE = 1 and LED alternates 8'hFF / 8'h00 every BLINK_TICKS ticks, starting with 8'hFF.
  - SOUTH reloads the digits from preset and goes to IDLE.
- NORTH in any state: digits = 0, goes to IDLE. preset is unchanged.
- Tick prescaler counts 0..TICK_DIV-1 only in RUN and EXPIRED. Outside those states it is held at 0. On entry to RUN or EXPIRED it restarts from 0. The tick pulse fires when the count equals TICK_DIV-1.
- Elapsed sub-tick time is discarded on pause. The first decrement after entering RUN occurs exactly TICK_DIV cycles later.
- Reset (RST_N low): state IDLE, digits 0, preset 0, prescaler 0, blink phase 0, lockout counters 0, LED 8'h00, DONE 0. Reset mid-RUN aborts immediately with no tick completing.

## Timing
- Button input to pulse: 3 cycles (2 synchroniser + edge register).
- Pulse to state/digit update: 1 cycle. LED and DONE are registered: 1 cycle after the state or digit change.
- Tick to digit update: 1 cycle. The final decrement and DONE rise are 2 cycles apart (digit update, then registered DONE).
- SW change to LED: 1 cycle.

## Structure
- Package countdown_timer_pkg holds:
  - state enum (IDLE, RUN, PAUSE, EXPIRED);
  - bcd_digit_t (4-bit);
  - constants for LED flash patterns 8'hFF / 8'h00.
- Sub-module button_conditioner (synchroniser, edge detect, DEBOUNCE lockout, 1-cycle pulse out), instantiated three times.
- BCD increment/decrement is a package function, not a module.

## Test plan
Benches use TICK_DIV=4, DEBOUNCE=8, BLINK_TICKS=2.
- Reset/preset: RST_N low then high, EAST ×3 spaced 20 cycles, SW=1 → LED=8'h03, DONE=0, state IDLE.
- Borrow chain: preset 10 s, SOUTH → after 1 tick LED(SW=1)=8'h09 and LED(SW=0)=8'h99. Tens/units wrap 99 → 00 with EAST ×100.
- Expiry: preset 1 s, SOUTH, run 100 ticks → DONE=1 exactly 2 cycles after the last tick, LED toggles FF/00 every 8 cycles. SOUTH then gives IDLE, LED(SW=1)=8'h01.
- Pause/zero start: SOUTH in IDLE at 00.00 → stays IDLE. In RUN, SOUTH then hold 50 cycles → digits unchanged; SOUTH again → first decrement 4 cycles after the resume pulse.
- Priority/debounce: SOUTH and NORTH rising same cycle during RUN → IDLE, digits 0. Bounce SOUTH 3 times within 8 cycles → exactly one pulse.
- Async reset mid-RUN: RST_N low asynchronously between clock edges → LED=8'h00 and DONE=0 immediately, before the next CLK_50M edge.
